// File: rtl/gpio_seq_pkg.sv
// gpio_seq_pkg: sequencer states and GPIO register map
package gpio_seq_pkg;
  typedef enum logic [3:0] {
    IDLE, CFG_EN, CFG_MASK, CFG_POL, CLR, ARMED, CAPTURE, ACK, PUSH, DIS_MASK, DIS_ACK
  } state_t;
  localparam logic [4:0] REG_DATA = 5'd0;
  localparam logic [4:0] REG_EN   = 5'd4;
  localparam logic [4:0] REG_MASK = 5'd8;
  localparam logic [4:0] REG_POL  = 5'd12;
  localparam logic [4:0] REG_ACK  = 5'd16;
endpackage

// File: rtl/gpio_seq_timestamp.sv
// gpio_seq_timestamp: free-running wrapping timestamp counter
module gpio_seq_timestamp #(
  parameter int TS_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  output logic [TS_W-1:0] ts
);
  always_ff @(posedge clk)
    ts <= reset ? '0 : ts + 1'b1;
endmodule

// File: rtl/gpio_irq_sequencer.sv
// gpio_irq_sequencer: Avalon master configuring a GPIO, servicing its irq and arbitrating data writes (timestamps with GPIO_SEQ_TIMESTAMP_EN)
module gpio_irq_sequencer
  import gpio_seq_pkg::*;
#(
  parameter int REARM_CYCLES = 2,
  parameter int TS_W         = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stop,
  input  logic [31:0]     cfg_enable,
  input  logic [31:0]     cfg_mask,
  input  logic [31:0]     cfg_pol,
  output logic [4:0]      avm_address,
  output logic            avm_write,
  output logic [31:0]     avm_writedata,
  input  logic [31:0]     avm_readdata,
  input  logic            irq_i,
  input  logic            out_req,
  input  logic [31:0]     out_data,
  output logic            out_gnt,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [31:0]     evt_data,
  output logic [TS_W-1:0] evt_ts,
  output logic            busy
);
  localparam int HW = $clog2(REARM_CYCLES + 1);
  localparam logic [HW-1:0] REARM = HW'(REARM_CYCLES);

  state_t state, state_n;
  logic [31:0] cfg_en_q, cfg_mask_q, cfg_pol_q;
  logic [HW-1:0] holdoff;
  logic stop_pend, rr_last;
  logic stop_now, pick_irq, pick_out;

  assign stop_now  = stop || stop_pend;
  // rr_last set means irq was served last, so a tie goes to the output requester
  assign pick_irq  = state == ARMED && !stop_now && irq_i && holdoff == '0 && (!out_req || !rr_last);
  assign pick_out  = state == ARMED && !stop_now && out_req && !pick_irq;
  assign evt_valid = state == PUSH;
  assign busy      = state != IDLE;

  always_comb begin
    state_n       = state;
    avm_write     = 1'b0;
    avm_address   = REG_DATA;
    avm_writedata = '0;
    out_gnt       = 1'b0;
    case (state)
      IDLE:     state_n = start ? CFG_EN : IDLE;
      CFG_EN:   begin avm_write = 1'b1; avm_address = REG_EN;   avm_writedata = cfg_en_q;   state_n = CFG_MASK; end
      CFG_MASK: begin avm_write = 1'b1; avm_address = REG_MASK; avm_writedata = cfg_mask_q; state_n = CFG_POL;  end
      CFG_POL:  begin avm_write = 1'b1; avm_address = REG_POL;  avm_writedata = cfg_pol_q;  state_n = CLR;      end
      CLR:      begin avm_write = 1'b1; avm_address = REG_ACK;  state_n = ARMED; end
      ARMED: begin
        state_n       = stop_now ? DIS_MASK : pick_irq ? CAPTURE : ARMED;
        avm_write     = pick_out;
        out_gnt       = pick_out;
        avm_writedata = pick_out ? out_data : '0;
      end
      CAPTURE:  state_n = ACK;
      ACK:      begin avm_write = 1'b1; avm_address = REG_ACK; state_n = PUSH; end
      PUSH:     state_n = evt_ready ? ARMED : PUSH;
      DIS_MASK: begin avm_write = 1'b1; avm_address = REG_MASK; state_n = DIS_ACK; end
      DIS_ACK:  begin avm_write = 1'b1; avm_address = REG_ACK;  state_n = IDLE; end
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cfg_en_q   <= '0;
      cfg_mask_q <= '0;
      cfg_pol_q  <= '0;
      holdoff    <= '0;
      stop_pend  <= 1'b0;
      rr_last    <= 1'b0;
      evt_data   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        cfg_en_q   <= cfg_enable;
        cfg_mask_q <= cfg_mask;
        cfg_pol_q  <= cfg_pol;
      end
      holdoff <= (state == CLR || state == ACK) ? REARM :
                 ((state == ARMED || state == PUSH) && holdoff != '0) ? holdoff - 1'b1 : holdoff;
      stop_pend <= state == DIS_ACK ? 1'b0 :
                   (stop && state != IDLE && state != ARMED) ? 1'b1 : stop_pend;
      rr_last <= pick_irq ? 1'b1 : pick_out ? 1'b0 : rr_last;
      if (state == CAPTURE) evt_data <= avm_readdata;
    end
  end

`ifdef GPIO_SEQ_TIMESTAMP_EN
  logic [TS_W-1:0] ts;
  gpio_seq_timestamp #(.TS_W(TS_W)) u_ts (.clk(clk), .reset(reset), .ts(ts));
  always_ff @(posedge clk)
    if (reset) evt_ts <= '0;
    else if (state == CAPTURE) evt_ts <= ts;
`else
  assign evt_ts = {TS_W{1'b0}};
`endif
endmodule

// File: tb/tb_gpio_irq_sequencer.sv
// tb_gpio_irq_sequencer: randomized bench with a GPIO slave model (2-cycle ack-to-irq-clear)
module tb_gpio_irq_sequencer;
  localparam int TS_W = 32;
  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, stop = 1'b0, out_req = 1'b0, evt_ready = 1'b0;
  logic [31:0] cfg_enable = '0, cfg_mask = '0, cfg_pol = '0, out_data = '0, pio_i = '0;
  logic [4:0] avm_address;
  logic avm_write, out_gnt, evt_valid, busy;
  logic [31:0] avm_writedata, avm_readdata, evt_data;
  logic [TS_W-1:0] evt_ts;
  logic irq_i = 1'b0;
  int vectors = 0, miscompares = 0;
  logic [31:0] en_cfg = 32'hFF;

  always #5 clk = ~clk;

  gpio_irq_sequencer #(.REARM_CYCLES(2), .TS_W(TS_W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .cfg_enable(cfg_enable), .cfg_mask(cfg_mask), .cfg_pol(cfg_pol),
    .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .irq_i(irq_i), .out_req(out_req), .out_data(out_data),
    .out_gnt(out_gnt), .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .evt_ts(evt_ts), .busy(busy)
  );

  // GPIO slave model: sticky pending set by enabled & unmasked active inputs, cleared by ack
  logic [31:0] g_en = '0, g_mask = '0, g_pol = '0, g_out = '0;
  logic pend = 1'b0;
  always @(posedge clk) begin
    if (avm_write)
      case (avm_address)
        5'd0:  g_out  <= avm_writedata;
        5'd4:  g_en   <= avm_writedata;
        5'd8:  g_mask <= avm_writedata;
        5'd12: g_pol  <= avm_writedata;
        default: ;
      endcase
    pend  <= (avm_write && avm_address == 5'd16) ? 1'b0 : (pend | (|(g_en & g_mask & (pio_i ^ g_pol))));
    irq_i <= pend;
  end
  assign avm_readdata = avm_address == 5'd0 ? (g_en & pio_i) : avm_address == 5'd4 ? g_en :
                        avm_address == 5'd8 ? g_mask : avm_address == 5'd12 ? g_pol : 32'h0;

  logic [4:0] wa[$];
  logic [31:0] wd[$];
  int wc[$];
  int cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (avm_write) begin
      wa.push_back(avm_address);
      wd.push_back(avm_writedata);
      wc.push_back(cyc);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log;
    wa.delete(); wd.delete(); wc.delete();
  endtask

  task automatic do_start(input logic [31:0] e, input logic [31:0] m, input logic [31:0] p);
    cfg_enable = e; cfg_mask = m; cfg_pol = p; en_cfg = e;
    start = 1'b1;
    tick;
    start = 1'b0;
    cfg_enable = $urandom; cfg_mask = $urandom; cfg_pol = $urandom;
    repeat (4) tick;
  endtask

  task automatic serve_irq(input logic [31:0] v, input int rdy, output int lat, output logic [31:0] d,
                           output logic [TS_W-1:0] ts, output bit held, output logic after_v);
    int n;
    pio_i = v; lat = -1; held = 1'b1;
    for (int i = 0; i < 20 && irq_i !== 1'b1; i++) tick;
    if (irq_i === 1'b1) begin
      n = 0;
      while (evt_valid !== 1'b1 && n < 10) begin tick; n++; end
      if (evt_valid === 1'b1) lat = n;
    end
    d = evt_data; ts = evt_ts;
    pio_i = '0;
    repeat (rdy) begin tick; if (evt_valid !== 1'b1) held = 1'b0; end
    evt_ready = 1'b1;
    tick;
    evt_ready = 1'b0;
    #1 after_v = evt_valid;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    vectors++;
    if ({busy, evt_valid, avm_write, out_gnt, avm_address, avm_writedata, evt_data, evt_ts} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got busy=%b v=%b w=%b g=%b a=%h wd=%h d=%h ts=%h exp all zero",
               busy, evt_valid, avm_write, out_gnt, avm_address, avm_writedata, evt_data, evt_ts);
    end
    reset = 1'b0;
    out_req = 1'b1; out_data = 32'hA5A5;
    tick;
    vectors++;
    if ({busy, out_gnt, avm_write} !== 3'b000) begin
      miscompares++;
      $display("FAIL idle_no_grant got busy=%b gnt=%b w=%b exp 000", busy, out_gnt, avm_write);
    end
    out_req = 1'b0;
  endtask

  task automatic test_config;
    logic [4:0] ea[4];
    logic [31:0] ed[4];
    ea = '{5'd4, 5'd8, 5'd12, 5'd16};
    ed = '{32'hFF, 32'h0F, 32'h00, 32'h0};
    clear_log;
    do_start(32'hFF, 32'h0F, 32'h00);
    vectors++;
    if (busy !== 1'b1 || wa.size() != 4) begin
      miscompares++;
      $display("FAIL cfg_writes got busy=%b nwrites=%0d exp busy=1 nwrites=4", busy, wa.size());
    end
    for (int i = 0; i < 4 && i < wa.size(); i++) begin
      vectors++;
      if (wa[i] !== ea[i] || (i < 3 && wd[i] !== ed[i]) || wc[i] != wc[0] + i) begin
        miscompares++;
        $display("FAIL cfg_write%0d got addr=%0d data=%h cyc+%0d exp addr=%0d data=%h cyc+%0d",
                 i, wa[i], wd[i], wc[i] - wc[0], ea[i], ed[i], i);
      end
    end
    clear_log;
    cfg_enable = 32'h1234; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (5) tick;
    vectors++;
    if (wa.size() != 0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL start_while_busy got nwrites=%0d busy=%b exp nwrites=0 busy=1", wa.size(), busy);
    end
  endtask

  task automatic test_irq;
    logic [31:0] v, d;
    logic [TS_W-1:0] ts;
    int lat;
    bit held;
    logic after_v;
    for (int it = 0; it < 6; it++) begin
      v = $urandom;
      v[$urandom_range(3, 0)] = 1'b1;
      serve_irq(v, $urandom_range(3, 0), lat, d, ts, held, after_v);
      vectors++;
      if (lat != 3) begin
        miscompares++;
        $display("FAIL irq_latency it%0d got %0d exp 3", it, lat);
      end
      vectors++;
      if (d !== (v & en_cfg)) begin
        miscompares++;
        $display("FAIL irq_data it%0d got %h exp %h", it, d, v & en_cfg);
      end
`ifndef GPIO_SEQ_TIMESTAMP_EN
      vectors++;
      if (ts !== '0) begin
        miscompares++;
        $display("FAIL irq_ts it%0d got %h exp 0", it, ts);
      end
`endif
      vectors++;
      if (!held || after_v !== 1'b0) begin
        miscompares++;
        $display("FAIL irq_handshake it%0d got held=%b after=%b exp held=1 after=0", it, held, after_v);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] v, od;
    v = $urandom | 32'h1;
    pio_i = v;
    for (int i = 0; i < 30 && evt_valid !== 1'b1; i++) tick;
    vectors++;
    if (evt_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_event_timeout got valid=%b exp 1", evt_valid);
    end
    pio_i = '0;
    od = $urandom;
    out_req = 1'b1; out_data = od;
    clear_log;
    for (int i = 0; i < 10; i++) begin
      #1;
      vectors++;
      if ({evt_valid, out_gnt} !== 2'b10) begin
        miscompares++;
        $display("FAIL bp_stall%0d got valid=%b gnt=%b exp valid=1 gnt=0", i, evt_valid, out_gnt);
      end
      tick;
    end
    evt_ready = 1'b1;
    #1;
    vectors++;
    if (out_gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_push_gnt got %b exp 0", out_gnt);
    end
    tick;
    evt_ready = 1'b0;
    #1;
    vectors++;
    if ({out_gnt, avm_write, avm_address, avm_writedata} !== {1'b1, 1'b1, 5'd0, od}) begin
      miscompares++;
      $display("FAIL bp_release got gnt=%b w=%b a=%0d wd=%h exp gnt=1 w=1 a=0 wd=%h",
               out_gnt, avm_write, avm_address, avm_writedata, od);
    end
    tick;
    out_req = 1'b0;
    vectors++;
    if (wa.size() != 1 || g_out !== od) begin
      miscompares++;
      $display("FAIL bp_single_write got nwrites=%0d gpio_out=%h exp 1 %h", wa.size(), g_out, od);
    end
  endtask

  task automatic test_out_random;
    logic [31:0] od;
    for (int it = 0; it < 8; it++) begin
      repeat ($urandom_range(3, 0)) tick;
      od = $urandom;
      out_req = 1'b1; out_data = od;
      #1;
      vectors++;
      if ({out_gnt, avm_write, avm_address, avm_writedata} !== {1'b1, 1'b1, 5'd0, od}) begin
        miscompares++;
        $display("FAIL out_grant it%0d got gnt=%b w=%b a=%0d wd=%h exp gnt=1 w=1 a=0 wd=%h",
                 it, out_gnt, avm_write, avm_address, avm_writedata, od);
      end
      tick;
      out_req = 1'b0;
      vectors++;
      if (g_out !== od) begin
        miscompares++;
        $display("FAIL out_gpio it%0d got %h exp %h", it, g_out, od);
      end
    end
  endtask

  task automatic test_rr;
    logic [31:0] v, od;
    reset = 1'b1;
    tick; tick;
    vectors++;
    if ({busy, evt_data} !== '0) begin
      miscompares++;
      $display("FAIL midrun_reset got busy=%b data=%h exp 0 0", busy, evt_data);
    end
    reset = 1'b0;
    do_start(32'hFF, 32'h0F, 32'h00);
    v = $urandom | 32'h2;
    pio_i = v;
    tick; tick;
    od = $urandom;
    out_req = 1'b1; out_data = od;
    #1;
    vectors++;
    if ({irq_i, out_gnt} !== 2'b10) begin
      miscompares++;
      $display("FAIL rr_first got irq=%b gnt=%b exp irq=1 gnt=0", irq_i, out_gnt);
    end
    for (int i = 0; i < 10 && evt_valid !== 1'b1; i++) tick;
    vectors++;
    if (evt_valid !== 1'b1 || evt_data !== (v & en_cfg)) begin
      miscompares++;
      $display("FAIL rr_first_event got valid=%b data=%h exp 1 %h", evt_valid, evt_data, v & en_cfg);
    end
    tick; tick;
    evt_ready = 1'b1;
    tick;
    evt_ready = 1'b0;
    #1;
    vectors++;
    if ({irq_i, out_gnt, avm_writedata} !== {2'b11, od}) begin
      miscompares++;
      $display("FAIL rr_second got irq=%b gnt=%b wd=%h exp irq=1 gnt=1 wd=%h", irq_i, out_gnt, avm_writedata, od);
    end
    tick;
    out_req = 1'b0;
    for (int i = 0; i < 10 && evt_valid !== 1'b1; i++) tick;
    vectors++;
    if (evt_valid !== 1'b1 || evt_data !== (v & en_cfg)) begin
      miscompares++;
      $display("FAIL rr_second_event got valid=%b data=%h exp 1 %h", evt_valid, evt_data, v & en_cfg);
    end
    pio_i = '0;
    evt_ready = 1'b1;
    tick;
    evt_ready = 1'b0;
  endtask

`ifdef GPIO_SEQ_TIMESTAMP_EN
  task automatic test_timestamp;
    logic [31:0] d;
    logic [TS_W-1:0] ts1, ts2;
    int lat, s1;
    bit held;
    logic after_v;
    repeat (3) tick;
    s1 = cyc;
    serve_irq(32'h1, 0, lat, d, ts1, held, after_v);
    while (cyc < s1 + 100) tick;
    serve_irq(32'h2, 0, lat, d, ts2, held, after_v);
    vectors++;
    if (ts2 - ts1 !== TS_W'(100)) begin
      miscompares++;
      $display("FAIL ts_delta got %0d exp 100", ts2 - ts1);
    end
  endtask
`endif

  task automatic test_stop;
    logic [31:0] v;
    int seen;
    v = $urandom | 32'h4;
    repeat (3) tick;
    pio_i = v;
    for (int i = 0; i < 20 && evt_valid !== 1'b1; i++) tick;
    stop = 1'b1;
    clear_log;
    tick;
    stop = 1'b0;
    vectors++;
    if (evt_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL stop_event_kept got valid=%b exp 1", evt_valid);
    end
    evt_ready = 1'b1;
    tick;
    evt_ready = 1'b0;
    for (int i = 0; i < 10 && busy !== 1'b0; i++) tick;
    vectors++;
    if (busy !== 1'b0 || wa.size() != 2) begin
      miscompares++;
      $display("FAIL stop_idle got busy=%b nwrites=%0d exp busy=0 nwrites=2", busy, wa.size());
    end else begin
      vectors++;
      if (wa[0] !== 5'd8 || wd[0] !== 32'h0 || wa[1] !== 5'd16 || wc[1] != wc[0] + 1) begin
        miscompares++;
        $display("FAIL stop_writes got (%0d,%h),(%0d) gap %0d exp (8,0),(16) gap 1",
                 wa[0], wd[0], wa[1], wc[1] - wc[0]);
      end
    end
    seen = 0;
    repeat (20) begin
      tick;
      if (evt_valid || busy) seen++;
    end
    vectors++;
    if (seen != 0 || wa.size() != 2) begin
      miscompares++;
      $display("FAIL stop_quiet got active_cycles=%0d nwrites=%0d exp 0 2", seen, wa.size());
    end
    pio_i = '0;
  endtask

  initial begin
    test_reset;
    test_config;
    test_irq;
    test_backpressure;
    test_out_random;
    test_rr;
`ifdef GPIO_SEQ_TIMESTAMP_EN
    test_timestamp;
`endif
    test_stop;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end
endmodule
